// File: rtl/wb_stage.sv
// Write-back stage: registers the MEM result, aligns/extends load data and drives the RF write port and WB-to-ID bypass bus.
// Optional commit trace on the debug_* ports is built only when WB_DEBUG_TRACE_EN is defined.
module wb_stage #(
    parameter int WB_TO_ID_WD  = 38,
    parameter int MEM_TO_WB_WD = 75
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    mem_valid,
    input  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    stall_wb,
    input  logic                    flush,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    output logic [WB_TO_ID_WD-1:0]  wb_to_id_bus,
    output logic [31:0]             debug_wb_pc,
    output logic [3:0]              debug_wb_rf_wen,
    output logic [4:0]              debug_wb_rf_wnum,
    output logic [31:0]             debug_wb_rf_wdata
);

    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LD_B    = 3'b001,
        LD_BU   = 3'b010,
        LD_H    = 3'b011,
        LD_HU   = 3'b100,
        LD_W    = 3'b101
    } ld_type_e;

    logic        valid;
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    logic [31:0] hold_data;
    logic        hold_vld;
    logic        is_load;
    logic [31:0] load_src;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] result;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid   <= 1'b0;
            ld_type <= 3'b000;
            addr_lo <= 2'b00;
            we      <= 1'b0;
            waddr   <= 5'd0;
            wdata   <= 32'd0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!stall_wb) begin
            valid   <= mem_valid;
            ld_type <= mem_to_wb_bus[42:40];
            addr_lo <= mem_to_wb_bus[39:38];
            we      <= mem_to_wb_bus[37];
            waddr   <= mem_to_wb_bus[36:32];
            wdata   <= mem_to_wb_bus[31:0];
        end
    end

    always_comb begin
        is_load = 1'b0;
        case (ld_type)
            LD_B, LD_BU, LD_H, LD_HU, LD_W: is_load = 1'b1;
            default:                        is_load = 1'b0;
        endcase
    end

    // SRAM output is only valid in the first WB cycle, so a stalled load keeps its own copy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_vld  <= 1'b0;
            hold_data <= 32'd0;
        end else if (flush || !stall_wb) begin
            hold_vld <= 1'b0;
        end else if (valid && is_load && !hold_vld) begin
            hold_vld  <= 1'b1;
            hold_data <= data_sram_rdata;
        end
    end

    always_comb begin
        load_src = hold_vld ? hold_data : data_sram_rdata;
        case (addr_lo)
            2'd0:    load_byte = load_src[7:0];
            2'd1:    load_byte = load_src[15:8];
            2'd2:    load_byte = load_src[23:16];
            default: load_byte = load_src[31:24];
        endcase
        load_half = addr_lo[1] ? load_src[31:16] : load_src[15:0];
        case (ld_type)
            LD_B:    result = {{24{load_byte[7]}}, load_byte};
            LD_BU:   result = {24'd0, load_byte};
            LD_H:    result = {{16{load_half[15]}}, load_half};
            LD_HU:   result = {16'd0, load_half};
            LD_W:    result = load_src;
            default: result = wdata;
        endcase
    end

    assign rf_we        = valid & we;
    assign rf_waddr     = waddr;
    assign rf_wdata     = result;
    assign wb_to_id_bus = {rf_we, rf_waddr, rf_wdata};

`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] pc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc <= 32'd0;
        end else if (!flush && !stall_wb) begin
            pc <= mem_to_wb_bus[74:43];
        end
    end

    // Suppressing the enable while stalled makes each retired write show up once.
    assign debug_wb_pc       = pc;
    assign debug_wb_rf_wen   = {4{rf_we & ~stall_wb}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`else
    logic unused_pc;

    assign unused_pc         = ^mem_to_wb_bus[74:43];
    assign debug_wb_pc       = 32'd0;
    assign debug_wb_rf_wen   = 4'd0;
    assign debug_wb_rf_wnum  = 5'd0;
    assign debug_wb_rf_wdata = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: ALU writes, load alignment, stall hold, flush and async reset.
module tb_wb_stage;

    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic [74:0] mem_to_wb_bus;
    logic [31:0] data_sram_rdata;
    logic        stall_wb;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [37:0] wb_to_id_bus;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int checks;
    int failures;
    logic trace_on;

    wb_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .mem_valid        (mem_valid),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .data_sram_rdata  (data_sram_rdata),
        .stall_wb         (stall_wb),
        .flush            (flush),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .wb_to_id_bus     (wb_to_id_bus),
        .debug_wb_pc      (debug_wb_pc),
        .debug_wb_rf_wen  (debug_wb_rf_wen),
        .debug_wb_rf_wnum (debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [2:0] ld, input logic [1:0] alo,
                                 input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [31:0] pc);
        mem_valid     = v;
        mem_to_wb_bus = {pc, ld, alo, w, wa, wd};
    endtask

    task automatic checkOutput(input string tag, input logic [37:0] observed, input logic [37:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
`ifdef WB_DEBUG_TRACE_EN
        trace_on = 1'b1;
`else
        trace_on = 1'b0;
`endif
        resetn          = 1'b0;
        stall_wb        = 1'b0;
        flush           = 1'b0;
        data_sram_rdata = 32'hFFFF_FFFF;
        applyStimulus(1'b0, 3'b000, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        #2;
        checkOutput("reset_rf_we", {37'd0, rf_we}, 38'd0);
        checkOutput("reset_rf_wdata", {6'd0, rf_wdata}, 38'd0);
        checkOutput("reset_bus", wb_to_id_bus, 38'd0);
        checkOutput("reset_dbg_wen", {34'd0, debug_wb_rf_wen}, 38'd0);
        checkOutput("reset_dbg_pc", {6'd0, debug_wb_pc}, 38'd0);
        step();
        resetn = 1'b1;
        step();

        // ALU result
        applyStimulus(1'b1, 3'b000, 2'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_1000);
        step();
        checkOutput("alu_rf_we", {37'd0, rf_we}, 38'd1);
        checkOutput("alu_rf_waddr", {33'd0, rf_waddr}, 38'd5);
        checkOutput("alu_bus", wb_to_id_bus, {1'b1, 5'd5, 32'h1234_5678});
        checkOutput("alu_dbg_pc", {6'd0, debug_wb_pc}, {6'd0, trace_on ? 32'h0000_1000 : 32'd0});
        checkOutput("alu_dbg_wen", {34'd0, debug_wb_rf_wen}, {34'd0, trace_on ? 4'hF : 4'h0});

        // lb, byte 2, sign-extend
        applyStimulus(1'b1, 3'b001, 2'd2, 1'b1, 5'd3, 32'hDEAD_DEAD, 32'h0000_1004);
        step();
        data_sram_rdata = 32'h0080_0000;
        #1;
        checkOutput("lb_sext", {6'd0, rf_wdata}, {6'd0, 32'hFFFF_FF80});

        // back-to-back lbu then lhu, no stall
        applyStimulus(1'b1, 3'b010, 2'd3, 1'b1, 5'd4, 32'd0, 32'h0000_1008);
        step();
        data_sram_rdata = 32'hBEEF_0000;
        #1;
        checkOutput("lbu_zext", {6'd0, rf_wdata}, {6'd0, 32'h0000_00BE});
        applyStimulus(1'b1, 3'b100, 2'd2, 1'b1, 5'd6, 32'd0, 32'h0000_100C);
        step();
        checkOutput("lhu_zext", {6'd0, rf_wdata}, {6'd0, 32'h0000_BEEF});

        // lh low half with sign bit set, addr_lo[0] ignored
        applyStimulus(1'b1, 3'b011, 2'd1, 1'b1, 5'd6, 32'd0, 32'h0000_1010);
        step();
        data_sram_rdata = 32'h1234_8001;
        #1;
        checkOutput("lh_sext", {6'd0, rf_wdata}, {6'd0, 32'hFFFF_8001});

        // lb byte 0 positive, and reserved ld_type 110 passes wdata
        applyStimulus(1'b1, 3'b001, 2'd0, 1'b1, 5'd2, 32'd0, 32'h0000_1014);
        step();
        data_sram_rdata = 32'hAABB_CC7E;
        #1;
        checkOutput("lb_pos", {6'd0, rf_wdata}, {6'd0, 32'h0000_007E});
        applyStimulus(1'b1, 3'b110, 2'd0, 1'b1, 5'd2, 32'h0BAD_F00D, 32'h0000_1018);
        step();
        checkOutput("ld110_wdata", {6'd0, rf_wdata}, {6'd0, 32'h0BAD_F00D});

        // invalid slot does not write
        applyStimulus(1'b0, 3'b000, 2'd0, 1'b1, 5'd2, 32'h1111_1111, 32'd0);
        step();
        checkOutput("invalid_rf_we", {37'd0, rf_we}, 38'd0);

        // lw held across a 3-cycle stall
        applyStimulus(1'b1, 3'b101, 2'd0, 1'b1, 5'd9, 32'd0, 32'h0000_0100);
        step();
        data_sram_rdata = 32'hCAFE_F00D;
        stall_wb        = 1'b1;
        applyStimulus(1'b1, 3'b000, 2'd0, 1'b1, 5'd10, 32'h0000_0055, 32'h0000_0104);
        #1;
        checkOutput("hold_c1_data", {6'd0, rf_wdata}, {6'd0, 32'hCAFE_F00D});
        checkOutput("hold_c1_wen", {34'd0, debug_wb_rf_wen}, 38'd0);
        step();
        data_sram_rdata = 32'h0000_0000;
        #1;
        checkOutput("hold_c2_data", {6'd0, rf_wdata}, {6'd0, 32'hCAFE_F00D});
        checkOutput("hold_c2_we", {32'd0, rf_we, rf_waddr}, {32'd0, 1'b1, 5'd9});
        checkOutput("hold_c2_wen", {34'd0, debug_wb_rf_wen}, 38'd0);
        step();
        checkOutput("hold_c3_data", {6'd0, rf_wdata}, {6'd0, 32'hCAFE_F00D});
        checkOutput("hold_c3_wen", {34'd0, debug_wb_rf_wen}, 38'd0);
        step();
        stall_wb = 1'b0;
        #1;
        checkOutput("release_data", {6'd0, rf_wdata}, {6'd0, 32'hCAFE_F00D});
        checkOutput("release_bus", wb_to_id_bus, {1'b1, 5'd9, 32'hCAFE_F00D});
        checkOutput("release_wen", {34'd0, debug_wb_rf_wen}, {34'd0, trace_on ? 4'hF : 4'h0});
        step();
        checkOutput("after_release", wb_to_id_bus, {1'b1, 5'd10, 32'h0000_0055});

        // flush with stall wins over a valid incoming write
        applyStimulus(1'b1, 3'b000, 2'd0, 1'b1, 5'd7, 32'h0000_0077, 32'h0000_0200);
        step();
        checkOutput("r7_write", wb_to_id_bus, {1'b1, 5'd7, 32'h0000_0077});
        applyStimulus(1'b1, 3'b000, 2'd0, 1'b1, 5'd8, 32'h0000_0088, 32'h0000_0204);
        flush    = 1'b1;
        stall_wb = 1'b1;
        step();
        flush    = 1'b0;
        stall_wb = 1'b0;
        applyStimulus(1'b0, 3'b000, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        #1;
        checkOutput("flush_rf_we", {37'd0, rf_we}, 38'd0);
        checkOutput("flush_bus37", {37'd0, wb_to_id_bus[37]}, 38'd0);

        // async reset while a load is held
        applyStimulus(1'b1, 3'b101, 2'd0, 1'b1, 5'd4, 32'd0, 32'h0000_0300);
        step();
        data_sram_rdata = 32'h1234_5678;
        stall_wb        = 1'b1;
        step();
        data_sram_rdata = 32'h0000_0000;
        #1;
        checkOutput("rst_held_data", {6'd0, rf_wdata}, {6'd0, 32'h1234_5678});
        #2;
        resetn          = 1'b0;
        data_sram_rdata = 32'hFFFF_FFFF;
        #1;
        checkOutput("rst_mid_we", {37'd0, rf_we}, 38'd0);
        checkOutput("rst_mid_wdata", {6'd0, rf_wdata}, 38'd0);
        checkOutput("rst_mid_dbg", {debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata[28:0]}, 38'd0);
        checkOutput("rst_mid_dbg_pc", {6'd0, debug_wb_pc}, 38'd0);
        #2;
        resetn   = 1'b1;
        stall_wb = 1'b0;
        applyStimulus(1'b0, 3'b000, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        step();
        checkOutput("rst_dropped", {37'd0, rf_we}, 38'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
